// File: rtl/fetch_decode.sv
// Instruction fetch and decode stage: a 4-state fetch/capture/present loop
// with redirect support and optional NOP squashing.
module fetch_decode #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic       SKIP_NOP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        rom_read,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        jump_en,
  input  logic [7:0]  jump_addr,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [3:0]  opcode,
  output logic [5:0]  dst,
  output logic [5:0]  src,
  output logic        cls_reg2,
  output logic        cls_single,
  output logic        cls_imm,
  output logic        cls_load,
  output logic        cls_illegal,
  output logic [7:0]  pc_out
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned OP_W  = 4;
  localparam int unsigned FLD_W = 6;
  localparam int unsigned CLS_W = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_e;

  // Class vector bit order: {reg2, single, imm, load, illegal}
  localparam logic [CLS_W-1:0] CLS_NONE    = 5'b00000;
  localparam logic [CLS_W-1:0] CLS_REG2    = 5'b10000;
  localparam logic [CLS_W-1:0] CLS_SINGLE  = 5'b01000;
  localparam logic [CLS_W-1:0] CLS_IMM     = 5'b00100;
  localparam logic [CLS_W-1:0] CLS_LOAD    = 5'b00010;
  localparam logic [CLS_W-1:0] CLS_ILLEGAL = 5'b00001;

  state_e             state_q,     state_d;
  logic [PC_W-1:0]    pc_q,        pc_d;
  logic [PC_W-1:0]    fetch_pc_q,  fetch_pc_d;
  logic               rom_read_q,  rom_read_d;
  logic               dec_valid_q, dec_valid_d;
  logic [OP_W-1:0]    opcode_q,    opcode_d;
  logic [FLD_W-1:0]   dst_q,       dst_d;
  logic [FLD_W-1:0]   src_q,       src_d;
  logic [CLS_W-1:0]   cls_q,       cls_d;
  logic [PC_W-1:0]    pc_out_q,    pc_out_d;

  logic               is_nop_c;
  logic               capture_c;
  logic [CLS_W-1:0]   rom_cls_c;

  // Opcode to one-hot class map for the word arriving from the ROM
  always_comb begin
    rom_cls_c = CLS_NONE;
    case (rom_data[15:12])
      4'h1, 4'h2, 4'h3, 4'h4,
      4'h5, 4'h6, 4'hA, 4'hB: rom_cls_c = CLS_REG2;
      4'h7, 4'h8, 4'h9:       rom_cls_c = CLS_SINGLE;
      4'hC:                   rom_cls_c = CLS_IMM;
      4'hD:                   rom_cls_c = CLS_LOAD;
      4'hE, 4'hF:             rom_cls_c = CLS_ILLEGAL;
      default:                rom_cls_c = CLS_NONE;
    endcase
  end

  assign is_nop_c  = SKIP_NOP && (rom_data == 16'h0000);
  // A redirect in CAPTURE discards the arriving word instead of latching it
  assign capture_c = (state_q == CAPTURE) && !is_nop_c && !jump_en;

  // Next-state, PC and decode register update
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    opcode_d   = opcode_q;
    dst_d      = dst_q;
    src_d      = src_q;
    cls_d      = cls_q;
    pc_out_d   = pc_out_q;

    case (state_q)
      IDLE: begin
        if (run) state_d = FETCH;
      end
      FETCH: begin
        fetch_pc_d = pc_q;
        pc_d       = pc_q + PC_W'(1);
        state_d    = CAPTURE;
      end
      CAPTURE: begin
        if (is_nop_c) state_d = run ? FETCH : IDLE;
        else          state_d = PRESENT;
      end
      PRESENT: begin
        if (dec_ready) state_d = run ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture_c) begin
      opcode_d = rom_data[15:12];
      dst_d    = rom_data[11:6];
      src_d    = rom_data[5:0];
      cls_d    = rom_cls_c;
      pc_out_d = fetch_pc_q;
    end

    // Redirect overrides every state; a same-cycle handshake is still consumed
    if (jump_en) begin
      pc_d    = jump_addr;
      state_d = run ? FETCH : IDLE;
    end
  end

  // Strobes are registered copies of the upcoming state decode
  always_comb begin
    rom_read_d  = (state_d == FETCH);
    dec_valid_d = (state_d == PRESENT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PC_RESET;
      fetch_pc_q  <= PC_RESET;
      rom_read_q  <= 1'b0;
      dec_valid_q <= 1'b0;
      opcode_q    <= '0;
      dst_q       <= '0;
      src_q       <= '0;
      cls_q       <= CLS_NONE;
      pc_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      rom_read_q  <= rom_read_d;
      dec_valid_q <= dec_valid_d;
      opcode_q    <= opcode_d;
      dst_q       <= dst_d;
      src_q       <= src_d;
      cls_q       <= cls_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign rom_read    = rom_read_q;
  assign rom_addr    = pc_q;
  assign dec_valid   = dec_valid_q;
  assign opcode      = opcode_q;
  assign dst         = dst_q;
  assign src         = src_q;
  assign cls_reg2    = cls_q[4];
  assign cls_single  = cls_q[3];
  assign cls_imm     = cls_q[2];
  assign cls_load    = cls_q[1];
  assign cls_illegal = cls_q[0];
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: ROM model, scoreboard of presented
// instructions checked on every handshake, plus cycle-level spot checks.
module tb_fetch_decode;

  logic        clk;
  logic        rst;
  logic        run;
  logic        rom_read;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        dec_valid;
  logic        dec_ready;
  logic [3:0]  opcode;
  logic [5:0]  dst;
  logic [5:0]  src;
  logic        cls_reg2, cls_single, cls_imm, cls_load, cls_illegal;
  logic [7:0]  pc_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [256];
  logic [28:0] sb [$];

  fetch_decode #(.PC_RESET(8'h00), .SKIP_NOP(1'b1)) dut (
    .clk(clk), .rst(rst), .run(run),
    .rom_read(rom_read), .rom_addr(rom_addr), .rom_data(rom_data),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .dst(dst), .src(src),
    .cls_reg2(cls_reg2), .cls_single(cls_single), .cls_imm(cls_imm),
    .cls_load(cls_load), .cls_illegal(cls_illegal),
    .pc_out(pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM answers one cycle after a sampled read strobe
  initial rom_data = 16'h0000;
  always @(posedge clk) if (rom_read) rom_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected presentation: {pc, opcode, dst, src, reg2, single, imm, load, illegal}
  function automatic logic [28:0] exp_of(input logic [7:0] a);
    logic [15:0] w;
    logic [4:0]  c;
    w = mem[a];
    case (w[15:12])
      4'h0:                   c = 5'b00000;
      4'h7, 4'h8, 4'h9:       c = 5'b01000;
      4'hC:                   c = 5'b00100;
      4'hD:                   c = 5'b00010;
      4'hE, 4'hF:             c = 5'b00001;
      default:                c = 5'b10000;
    endcase
    return {a, w[15:12], w[11:6], w[5:0], c};
  endfunction

  function automatic logic [28:0] obs_now();
    return {pc_out, opcode, dst, src, cls_reg2, cls_single, cls_imm, cls_load, cls_illegal};
  endfunction

  // Scoreboard: every accepted instruction must match the queue head
  always @(negedge clk) begin
    if (dec_valid === 1'b1 && dec_ready === 1'b1) begin
      chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) chk("insn", 32'(obs_now()), 32'(sb.pop_front()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch(input logic [7:0] target, input string tag);
    for (int i = 0; i < 200; i++) begin
      step();
      if (rom_read === 1'b1 && rom_addr === target) break;
    end
    chk(tag, {23'd0, rom_read, rom_addr}, {23'd0, 1'b1, target});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    mem[8'h00] = 16'h1042; mem[8'h01] = 16'h2FC1; mem[8'h02] = 16'h3ABC;
    mem[8'h03] = 16'h4123; mem[8'h04] = 16'h5FFF; mem[8'h05] = 16'h6040;
    mem[8'h06] = 16'h7001; mem[8'h07] = 16'h8FC0; mem[8'h08] = 16'h9555;
    mem[8'h09] = 16'hA1B2; mem[8'h0A] = 16'hB3C4; mem[8'h0B] = 16'hC04F;
    mem[8'h0C] = 16'hD123; mem[8'h0D] = 16'h0000; mem[8'h0E] = 16'h7100;
    mem[8'h0F] = 16'hF00F; mem[8'hFF] = 16'hE5A5;

    rst = 1'b1; run = 1'b0; jump_en = 1'b0; jump_addr = 8'h00; dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_read",  32'(rom_read),  32'd0);
    chk("rst_addr",  32'(rom_addr),  32'h00);
    chk("rst_dec",   32'(obs_now()), 32'd0);

    for (int a = 0; a <= 12; a++) sb.push_back(exp_of(8'(a)));
    sb.push_back(exp_of(8'h0E));

    // Cycle 0 idle, fetch in cycle 1, present in cycle 3
    rst = 1'b0; run = 1'b1; dec_ready = 1'b1;
    step();
    chk("c1_read",  32'(rom_read),  32'd1);
    chk("c1_addr",  32'(rom_addr),  32'h00);
    chk("c1_valid", 32'(dec_valid), 32'd0);
    step();
    chk("c2_read",  32'(rom_read),  32'd0);
    chk("c2_valid", 32'(dec_valid), 32'd0);
    step();
    chk("c3_valid", 32'(dec_valid), 32'd1);
    chk("c3_dec",   32'({opcode, dst, src, cls_reg2, pc_out}), 32'({4'h1, 6'd1, 6'd2, 1'b1, 8'h00}));

    // Backpressure on the immediate-class word at 0x0B
    wait_fetch(8'h0B, "fetch_0b");
    dec_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(dec_valid), 32'd1);
      chk("bp_read",  32'(rom_read),  32'd0);
      chk("bp_dec",   32'(obs_now()), 32'(exp_of(8'h0B)));
      chk("bp_imm",   32'({cls_imm, src}), 32'({1'b1, 6'h0F}));
      step();
    end
    dec_ready = 1'b1;

    // NOP at 0x0D is dropped; run falls during the fetch of 0x0E
    wait_fetch(8'h0E, "fetch_0e");
    run = 1'b0;
    step();
    chk("nop_cap_valid", 32'(dec_valid), 32'd0);
    step();
    chk("nop_pres", 32'({dec_valid, pc_out, cls_single}), 32'({1'b1, 8'h0E, 1'b1}));
    step();
    chk("idle_valid", 32'(dec_valid), 32'd0);
    chk("idle_read",  32'(rom_read),  32'd0);
    step();
    chk("idle_hold", 32'({rom_read, rom_addr}), 32'({1'b0, 8'h0F}));

    // Redirect from IDLE to 0xFF, then wrap to 0x00
    sb.push_back(exp_of(8'hFF));
    sb.push_back(exp_of(8'h00));
    sb.push_back(exp_of(8'h0C));
    run = 1'b1; jump_en = 1'b1; jump_addr = 8'hFF;
    step();
    chk("jmp_ff", 32'({rom_read, rom_addr}), 32'({1'b1, 8'hFF}));
    jump_en = 1'b0;
    step();
    step();
    chk("illegal_pres", 32'({dec_valid, cls_illegal, pc_out}), 32'({1'b1, 1'b1, 8'hFF}));
    step();
    chk("wrap_addr", 32'({rom_read, rom_addr}), 32'({1'b1, 8'h00}));
    step();
    step();
    chk("pres_00", 32'(dec_valid), 32'd1);

    // Redirect coinciding with the handshake
    jump_en = 1'b1; jump_addr = 8'h0C;
    step();
    chk("jmp_valid", 32'(dec_valid), 32'd0);
    chk("jmp_0c", 32'({rom_read, rom_addr}), 32'({1'b1, 8'h0C}));
    jump_en = 1'b0;
    step();
    step();
    chk("load_pres", 32'({dec_valid, cls_load, pc_out}), 32'({1'b1, 1'b1, 8'h0C}));
    step();
    chk("fetch_0d", 32'({rom_read, rom_addr}), 32'({1'b1, 8'h0D}));

    // Reset in CAPTURE beats a simultaneous redirect
    step();
    rst = 1'b1; jump_en = 1'b1; jump_addr = 8'h55; run = 1'b0;
    step();
    chk("mid_rst", 32'({dec_valid, rom_read, rom_addr}), 32'({1'b0, 1'b0, 8'h00}));
    chk("mid_rst_dec", 32'(obs_now()), 32'd0);
    rst = 1'b0; jump_en = 1'b0;
    step();
    chk("post_rst_idle", 32'({rom_read, rom_addr, dec_valid}), 32'({1'b0, 8'h00, 1'b0}));
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Parameters
REQ-001 The block SHALL have parameter PC_RESET, default 8'h00, the program counter value loaded on reset.
REQ-002 The block SHALL have parameter SKIP_NOP, default 1; when 1, fetched NOP words (16'h0000) are dropped and never presented downstream.

Interface
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 run  input  1  fetch enable; when low, no new fetch is started.
REQ-006 rom_read  output  1  read strobe to the instruction ROM.
REQ-007 rom_addr  output  8  ROM address, equal to the internal PC register.
REQ-008 rom_data  input  16  ROM word, valid the cycle after rom_read is sampled high.
REQ-009 jump_en  input  1  redirect request.
REQ-010 jump_addr  input  8  redirect target.
REQ-011 dec_valid  output  1  decoded instruction available.
REQ-012 dec_ready  input  1  downstream accepts the instruction.
REQ-013 opcode  output  4  instruction bits [15:12].
REQ-014 dst  output  6  instruction bits [11:6].
REQ-015 src  output  6  instruction bits [5:0]: register, immediate or direct address.
REQ-016 cls_reg2, cls_single, cls_imm, cls_load, cls_illegal  output  1 each  one-hot instruction class.
REQ-017 pc_out  output  8  address the presented instruction was fetched from.

Function
REQ-018 The FSM SHALL have states IDLE, FETCH, CAPTURE, PRESENT.
REQ-019 IDLE: rom_read=0; go to FETCH when run=1, otherwise stay.
REQ-020 FETCH: rom_read=1, rom_addr=PC, PC<=PC+1 (8-bit, 8'hFF wraps to 8'h00); go to CAPTURE.
REQ-021 CAPTURE: register rom_data into opcode/dst/src/class outputs and the fetch address into pc_out; go to PRESENT. Exception: if SKIP_NOP=1 and rom_data=16'h0000, go to FETCH if run=1, else IDLE.
REQ-022 PRESENT: dec_valid=1 and all decoded outputs held stable until dec_ready=1; on handshake go to FETCH if run=1, else IDLE.
REQ-023 Latency: fetch strobe in cycle N yields dec_valid=1 in cycle N+2; peak throughput is one instruction per 3 cycles.
REQ-024 Class decode: opcodes 1-6, A, B -> cls_reg2; 7, 8, 9 -> cls_single; C -> cls_imm; D -> cls_load; E, F -> cls_illegal; 0 -> all class bits 0.
REQ-025 Illegal opcodes SHALL be presented normally with cls_illegal=1; the block does not stall on them.
REQ-026 jump_en=1 in any state SHALL load PC<=jump_addr, discard any captured or in-flight word, and go to FETCH next cycle (IDLE if run=0).
REQ-027 If jump_en=1 and the PRESENT handshake occur in the same cycle, the instruction SHALL count as consumed and the redirect SHALL still apply.
REQ-028 dec_valid SHALL be 0 in the cycle after a redirect.
REQ-029 run dropping low SHALL NOT abort a FETCH/CAPTURE/PRESENT sequence in progress; the block goes to IDLE only after that instruction completes.
REQ-030 rom_read SHALL be high only in FETCH.

Reset
REQ-031 On rst=1 at a clock edge: state=IDLE, PC=PC_RESET, dec_valid=0, rom_read=0, opcode/dst/src=0, all class bits=0, pc_out=0.
REQ-032 rst SHALL take priority over jump_en and all handshakes, including mid-operation.

Verification
REQ-033 Reset, run=1, ROM[0]=16'h1042, dec_ready=1 -> rom_read in cycle 1, dec_valid in cycle 3 with opcode=1, dst=1, src=2, cls_reg2=1, pc_out=0.
REQ-034 ROM[0x0B]=16'hC04F, dec_ready held 0 for 5 cycles -> outputs stable, cls_imm=1, src=6'h0F; no further rom_read until ready.
REQ-035 SKIP_NOP=1, ROM[0x0D]=0, ROM[0x0E]=16'h7100 -> no dec_valid for 0x0D; next presented pc_out=0x0E, cls_single=1.
REQ-036 PC=8'hFF fetch -> next fetch address 8'h00.
REQ-037 jump_en=1, jump_addr=8'h0C during PRESENT with dec_ready=1 -> handshake completes, dec_valid=0 next cycle, next rom_addr=8'h0C, cls_load=1 for that word.
REQ-038 rst asserted in CAPTURE -> next cycle dec_valid=0, PC=PC_RESET, state IDLE.
